div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 91 +++++++++
 tb/tb_div_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit signed/unsigned restoring divider for HI/LO
//   clk, rst         : rising-edge clock, synchronous active-high reset
//   signed_div_i     : 1 = signed (DIV), 0 = unsigned (DIVU), sampled with start_i
//   opdata1_i/2_i    : dividend / divisor, sampled with start_i
//   start_i          : request, held high until the result is consumed
//   annul_i          : flush the operation in flight
//   result_o         : {remainder, quotient}, registered
//   ready_o          : result_o valid, registered
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);
    localparam logic [1:0] FREE = 2'd0, BYZERO = 2'd1, ON = 2'd2, END = 2'd3;
    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [31:0] dvd, dvs, rem;
    logic        neg_q, neg_r;
    logic [32:0] trial, diff;
    logic        n1, n2;
    // dvd shifts left each iteration: its MSB feeds the remainder, its LSB collects quotient bits
    assign trial = {rem, dvd[31]};
    assign diff  = trial - {1'b0, dvs};
    assign n1    = signed_div_i & opdata1_i[31];
    assign n2    = signed_div_i & opdata2_i[31];
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) state <= BYZERO;
                        else begin
                            state <= ON;
                            cnt   <= '0;
                            rem   <= '0;
                            dvd   <= n1 ? -opdata1_i : opdata1_i;
                            dvs   <= n2 ? -opdata2_i : opdata2_i;
                            neg_q <= n1 ^ n2;
                            neg_r <= n1;
                        end
                    end
                end
                BYZERO: begin
                    state    <= annul_i ? FREE : END;
                    ready_o  <= !annul_i;
                    result_o <= '0;
                end
                ON: begin
                    if (annul_i) begin
                        state <= FREE;
                        cnt   <= '0;
                        rem   <= '0;
                    end else if (cnt == 6'd32) begin
                        state    <= END;
                        ready_o  <= 1'b1;
                        result_o <= {neg_r ? -rem : rem, neg_q ? -dvd : dvd};
                    end else begin
                        rem <= diff[32] ? trial[31:0] : diff[31:0];
                        dvd <= {dvd[30:0], ~diff[32]};
                        cnt <= cnt + 6'd1;
                    end
                end
                default: begin
                    if (!start_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized self-checking bench for div_unit
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    int          checks = 0;
    int          failures = 0;
    logic [63:0] res;
    int          lat;
    bit          seen;

    div_unit dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
        .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns in END (or after a timeout) at a falling edge.
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b, input bit tog,
                         output logic [63:0] r, output int l);
        signed_div_i = s;
        opdata1_i = a;
        opdata2_i = b;
        start_i = 1'b1;
        l = 0;
        for (int i = 1; i <= 40 && l == 0; i++) begin
            @(negedge clk);
            if (tog) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                signed_div_i = 1'($urandom);
            end
            if (ready_o) l = i;
        end
        r = result_o;
    endtask

    task automatic end_op();
        start_i = 1'b0;
        @(negedge clk);
        check("release_ready", 64'(ready_o), 64'd0);
        check("release_result", result_o, 64'd0);
    endtask

    task automatic full_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b, input bit tog);
        logic [63:0] r;
        int l;
        do_op(s, a, b, tog, r, l);
        check({tag, "_lat"}, 64'(l), (b == 32'd0) ? 64'd2 : 64'd34);
        check({tag, "_res"}, r, ref_div(s, a, b));
        end_op();
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;
        do_op(1'b0, 32'hFFFFFFFF, 32'h10, 1'b0, res, lat);
        check("udiv16_lat", 64'(lat), 64'd34);
        check("udiv16_res", res, 64'h0000000F_0FFFFFFF);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        check("end_annul_ready", 64'(ready_o), 64'd1);
        check("end_annul_result", result_o, 64'h0000000F_0FFFFFFF);
        end_op();
        do_op(1'b1, 32'hFFFFFFF9, 32'h2, 1'b0, res, lat);
        check("sdiv_m7_2", res, 64'hFFFFFFFF_FFFFFFFD);
        end_op();
        do_op(1'b0, 32'hFFFFFFF9, 32'h2, 1'b0, res, lat);
        check("udiv_m7_2", res, 64'h00000001_7FFFFFFC);
        end_op();
        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, res, lat);
        check("sdiv_min_m1", res, 64'h00000000_80000000);
        end_op();
        do_op(1'b1, 32'h12345678, 32'h0, 1'b0, res, lat);
        check("byzero_lat", 64'(lat), 64'd2);
        check("byzero_res", res, 64'd0);
        end_op();
        // annul at iteration 10 (the 12th edge after start is sampled)
        signed_div_i = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        seen = 1'b0;
        repeat (11) begin
            @(negedge clk);
            seen |= ready_o;
        end
        annul_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            seen |= ready_o;
        end
        check("annul_result", result_o, 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= ready_o;
        end
        check("annul_never_ready", 64'(seen), 64'd0);
        do_op(1'b0, 32'd100, 32'd3, 1'b0, res, lat);
        check("annul_restart", res, 64'h00000001_00000021);
        end_op();
        // reset at iteration 20 with start held through release
        signed_div_i = 1'b1;
        opdata1_i = 32'hFFFFFF9C;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_result", result_o, 64'd0);
        rst = 1'b0;
        do_op(1'b1, 32'hFFFFFF9C, 32'd7, 1'b0, res, lat);
        check("rst_release_lat", 64'(lat), 64'd34);
        check("rst_release_res", res, ref_div(1'b1, 32'hFFFFFF9C, 32'd7));
        end_op();
        for (int i = 0; i < 1200; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 15) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            full_op("rand", 1'($urandom), a, b, 1'b1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
